// File: rtl/pulse_burst_arbiter.sv
// pulse_burst_arbiter
// Round-robin arbiter that lends one shared pulse output to N_REQ requesters.
// Each grant produces exactly one burst: ON_CYCLES cycles of sig high followed
// by OFF cycles, for PERIOD_CYCLES cycles in total, then one IDLE cycle before
// the next grant can be issued.
// Optional feature: define PULSE_ABORT_EN to add the abort port, which cancels
// the running burst without a done pulse.
`default_nettype none

module pulse_burst_arbiter #(
  parameter int N_REQ         = 4,
  parameter int ON_CYCLES     = 100_000_000,
  parameter int PERIOD_CYCLES = 300_000_000,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
`ifdef PULSE_ABORT_EN
  input  logic             abort,
`endif
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] done,
  output logic             busy,
  output logic             sig
);

  // Pointer wide enough to name any requester.
  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Terminal counts; cnt runs straight through ON and OFF without clearing.
  localparam logic [CNT_W-1:0] ON_LAST     = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_MAX     = PTR_W'(N_REQ - 1);
  localparam logic [PTR_W:0]   N_EXT       = (PTR_W + 1)'(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2
  } state_t;

  // Architectural state
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [PTR_W-1:0]   r_ptr;
  logic [N_REQ-1:0]   r_gnt;

  // Next-state values
  state_t             w_state_next;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [PTR_W-1:0]   w_ptr_next;
  logic [N_REQ-1:0]   w_gnt_next;

  // Arbitration
  logic [PTR_W-1:0]   w_cand [N_REQ];
  logic [N_REQ-1:0]   w_hit;
  logic               w_found;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W-1:0]   w_ptr_after;
  logic [N_REQ-1:0]   w_onehot;

  // Misc
  logic               w_abort;
  logic               w_term;

`ifdef PULSE_ABORT_EN
  assign w_abort = abort;
`else
  // No cancel path: every burst runs to its terminal count unless rst.
  assign w_abort = 1'b0;
`endif

  // Candidate at search offset gi is (ptr + gi) mod N_REQ. Since both terms
  // are below N_REQ, one conditional subtraction performs the wrap.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      logic [PTR_W:0] w_sum;
      assign w_sum       = {1'b0, r_ptr} + (PTR_W + 1)'(gi);
      assign w_cand[gi]  = (w_sum >= N_EXT) ? PTR_W'(w_sum - N_EXT)
                                            : w_sum[PTR_W-1:0];
      assign w_hit[gi]   = req[w_cand[gi]];
    end
  endgenerate

  // Pick the first requesting candidate starting at ptr (offset 0 has top
  // priority, so the scan runs downward and the lowest offset wins).
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_found  = 1'b1;
        w_winner = w_cand[k];
      end
    end
  end

  // Pointer moves one past the winner so the winner yields next time.
  assign w_ptr_after = (w_winner == PTR_MAX) ? '0 : w_winner + 1'b1;

  // One-hot decode of the winner index.
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign w_onehot[gi] = (w_winner == PTR_W'(gi));
    end
  endgenerate

  // Terminal cycle of a burst: last OFF cycle.
  assign w_term = (r_state == S_OFF) && (r_cnt == PERIOD_LAST);

  // Next-state logic: arbitration in IDLE, counting in ON/OFF, abort override.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_ptr_next   = r_ptr;
    w_gnt_next   = r_gnt;
    case (r_state)
      S_IDLE: begin
        // req is only looked at here; changes during a burst are ignored.
        if (w_found) begin
          w_state_next = S_ON;
          w_cnt_next   = '0;
          w_gnt_next   = w_onehot;
          w_ptr_next   = w_ptr_after;
        end
      end
      S_ON: begin
        if (w_abort) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_gnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == ON_LAST) begin
            w_state_next = S_OFF;
          end
        end
      end
      S_OFF: begin
        // Abort beats the terminal count, so an aborted burst never signals done.
        if (w_abort || (r_cnt == PERIOD_LAST)) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_gnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_gnt_next   = '0;
      end
    endcase
  end

  // State register; rst clears everything at once, discarding any burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_ptr   <= w_ptr_next;
      r_gnt   <= w_gnt_next;
    end
  end

  // Outputs are decoded from registered state only (plus abort for done).
  assign gnt  = r_gnt;
  assign sig  = (r_state == S_ON);
  assign busy = (r_state != S_IDLE);

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_done
      assign done[gi] = w_term & ~w_abort & r_gnt[gi];
    end
  endgenerate

endmodule

`default_nettype wire

// File: doc/pulse_burst_arbiter.md
PULSE_BURST_ARBITER -- requirements
Module: pulse_burst_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the pulse output (2..8).
REQ-002 Parameter ON_CYCLES, default 100_000_000, clk cycles sig is high per burst.
REQ-003 Parameter PERIOD_CYCLES, default 300_000_000, total clk cycles per burst (ON plus OFF).
REQ-004 Parameter CNT_W, default 32, burst counter width.
REQ-005 Port clk  input  1  single clock; all state updates on posedge.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port req  input  N_REQ  per-requester burst request, level.
REQ-008 Port abort  input  1  cancel current burst (present only with PULSE_ABORT_EN).
REQ-009 Port gnt  output  N_REQ  one-hot grant, held for the whole burst.
REQ-010 Port done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-011 Port busy  output  1  high whenever state is not IDLE.
REQ-012 Port sig  output  1  shared pulse output.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, ON, OFF, with a registered CNT_W-bit counter cnt.
REQ-014 In IDLE with req nonzero, the next edge SHALL register a one-hot gnt for the winner, clear cnt to 0 and enter ON.
REQ-015 Winner selection SHALL be round-robin: first set req bit searching upward from ptr, wrapping N_REQ-1 to 0.
REQ-016 On each grant, ptr SHALL update to (winner+1) mod N_REQ; ptr resets to 0.
REQ-017 In ON and OFF, cnt SHALL increment by 1 per cycle; ON SHALL transition to OFF on the edge where cnt == ON_CYCLES-1.
REQ-018 In OFF at cnt == PERIOD_CYCLES-1, the next edge SHALL enter IDLE and clear gnt.
REQ-019 sig SHALL be combinational: 1 iff state == ON; exactly ON_CYCLES high cycles per burst.
REQ-020 done SHALL be combinational: done = gnt when state == OFF and cnt == PERIOD_CYCLES-1, else 0.
REQ-021 Requester-to-grant latency SHALL be one cycle; grant-to-next-grant for back-to-back requests SHALL be PERIOD_CYCLES+1 cycles (one IDLE cycle between bursts).
REQ-022 req changes during ON/OFF SHALL be ignored; a deasserted req does not shorten the burst.
REQ-023 A requester still asserting req after its done SHALL be rearbitrated normally, yielding to other pending requesters.
REQ-024 Exactly one burst SHALL be issued per grant; gnt SHALL never have more than one bit set.
REQ-025 Parameters SHALL satisfy 1 <= ON_CYCLES < PERIOD_CYCLES <= 2^CNT_W-1; cnt SHALL never wrap.

Reset
REQ-026 rst high SHALL immediately force state IDLE, cnt 0, ptr 0, gnt 0, done 0, busy 0, sig 0, independent of clk.
REQ-027 rst asserted mid-burst SHALL discard the burst with no done pulse; after release, arbitration restarts from ptr 0.
REQ-028 First grant after rst release SHALL occur no earlier than the first posedge with rst low.

Configuration
REQ-029 Macro PULSE_ABORT_EN SHALL compile in the abort port and abort logic.
REQ-030 With PULSE_ABORT_EN: abort high in ON or OFF SHALL force IDLE, gnt 0, cnt 0 on the next edge, with no done pulse; sig is 0 from that edge.
REQ-031 With PULSE_ABORT_EN: abort in IDLE SHALL be ignored; abort and a terminal count in the same cycle SHALL favour abort (no done).
REQ-032 With PULSE_ABORT_EN: ptr SHALL keep its post-grant value after abort.
REQ-033 Without PULSE_ABORT_EN: no abort port; every granted burst runs to completion unless rst.

Verification (N_REQ=4, ON_CYCLES=3, PERIOD_CYCLES=8, CNT_W=4)
REQ-034 Single request: req=0010 at cycle 0 -> gnt=0010 from cycle 1, sig high cycles 1-3, done=0010 at cycle 8, gnt=0 from cycle 9.
REQ-035 Contention: req=1111 held -> grant order 0001,0010,0100,1000,0001, grants spaced 9 cycles.
REQ-036 Late drop: req=0100 for one cycle only -> full burst, 3 sig-high cycles, done=0100 at 8th burst cycle.
REQ-037 Reset mid-burst: rst high during ON cycle 2 -> gnt, sig, busy 0 before next posedge; no done; req=1000 after release -> gnt=1000.
REQ-038 Abort (PULSE_ABORT_EN): abort at OFF cnt=5 -> IDLE next edge, no done; pending req=0001 granted one cycle later.
REQ-039 Boundary: ON_CYCLES=1, PERIOD_CYCLES=2 -> sig high 1 cycle, done on 2nd burst cycle, regrant after 1 IDLE cycle.
